// File: rtl/gas_alarm_controller.sv
// gas_alarm_controller: persistence-filtered gas-level supervisor that
// drives ventilation fan, buzzer and gas shut-off valve through an
// IDLE/WARN/ALARM/COOL escalation machine and counts ALARM entries.
// Optional feature macro: GAS_ALARM_LATCH_EN (ALARM exit also needs ack).
module gas_alarm_controller #(
  parameter int unsigned WARN_LVL    = 3,
  parameter int unsigned ALARM_LVL   = 5,
  parameter int unsigned PERSIST     = 4,
  parameter int unsigned COOL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] level,
  input  logic       ack,
  output logic [1:0] state,
  output logic       fan_on,
  output logic       buzzer,
  output logic       valve_close,
  output logic [7:0] alarm_cnt
);

  localparam int unsigned LVL_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned COOL_W  = 16;
  localparam int unsigned ACNT_W  = 8;

  localparam logic [LVL_W-1:0]  WARN_L     = LVL_W'(WARN_LVL);
  localparam logic [LVL_W-1:0]  ALARM_L    = LVL_W'(ALARM_LVL);
  localparam logic [CNT_W-1:0]  PERSIST_C  = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0]  PERSIST_M1 = CNT_W'(PERSIST - 1);
  localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(COOL_CYCLES - 1);
  localparam logic [ACNT_W-1:0] ACNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    up_cnt, up_nxt, up_inc;
  logic [CNT_W-1:0]    dn_cnt, dn_nxt, dn_inc;
  logic [COOL_W-1:0]   cool_cnt, cool_nxt;
  logic                mute, mute_nxt;
  logic [ACNT_W-1:0]   alarm_cnt_nxt;
  logic                fan_nxt, buzzer_nxt, valve_nxt;
  logic [LVL_W-1:0]    up_thr;
  logic                up_smp, dn_smp, up_hit, dn_hit, exit_ok;

  // Per-sample qualification against the current state's thresholds
  assign up_thr = (state_q == ST_WARN) ? ALARM_L : WARN_L;
  assign up_smp = (level >= up_thr);
  assign dn_smp = (level < WARN_L);
  assign up_hit = up_smp && (up_cnt >= PERSIST_M1);
  assign dn_hit = dn_smp && (dn_cnt >= PERSIST_M1);
  assign up_inc = !up_smp ? '0 : ((up_cnt < PERSIST_C) ? up_cnt + CNT_W'(1) : up_cnt);
  assign dn_inc = !dn_smp ? '0 : ((dn_cnt < PERSIST_C) ? dn_cnt + CNT_W'(1) : dn_cnt);

`ifdef GAS_ALARM_LATCH_EN
  // Latching alarm: quiet gas alone is not enough, the user must acknowledge
  assign exit_ok = dn_hit && ack;
`else
  assign exit_ok = dn_hit;
`endif

  assign state = state_q;

  // Next-state, counter, mute and output-decode logic
  always_comb begin
    state_nxt     = state_q;
    up_nxt        = '0;
    dn_nxt        = '0;
    cool_nxt      = '0;
    mute_nxt      = 1'b0;
    alarm_cnt_nxt = alarm_cnt;
    fan_nxt       = 1'b0;
    buzzer_nxt    = 1'b0;
    valve_nxt     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (up_hit) state_nxt = ST_WARN;
      end
      ST_WARN: begin
        if (up_hit)      state_nxt = ST_ALARM;
        else if (dn_hit) state_nxt = ST_COOL;
      end
      ST_ALARM: begin
        if (exit_ok) state_nxt = ST_COOL;
      end
      ST_COOL: begin
        if (up_hit)                     state_nxt = ST_WARN;
        else if (cool_cnt == COOL_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Counters restart on any transition; otherwise track the active conditions
    if (state_nxt == state_q) begin
      if (state_q != ST_ALARM) up_nxt = up_inc;
      if ((state_q == ST_WARN) || (state_q == ST_ALARM)) dn_nxt = dn_inc;
      if (state_q == ST_COOL) cool_nxt = cool_cnt + COOL_W'(1);
    end

    // Mute lives only while ALARM is held
    if (state_nxt == ST_ALARM) begin
      mute_nxt = mute || ((state_q == ST_ALARM) && ack);
    end

    if ((state_nxt == ST_ALARM) && (state_q != ST_ALARM) && (alarm_cnt != ACNT_MAX)) begin
      alarm_cnt_nxt = alarm_cnt + ACNT_W'(1);
    end

    fan_nxt    = (state_nxt != ST_IDLE);
    valve_nxt  = (state_nxt == ST_ALARM);
    buzzer_nxt = (state_nxt == ST_ALARM) && !mute_nxt;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      up_cnt      <= '0;
      dn_cnt      <= '0;
      cool_cnt    <= '0;
      mute        <= 1'b0;
      alarm_cnt   <= '0;
      fan_on      <= 1'b0;
      buzzer      <= 1'b0;
      valve_close <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      up_cnt      <= up_nxt;
      dn_cnt      <= dn_nxt;
      cool_cnt    <= cool_nxt;
      mute        <= mute_nxt;
      alarm_cnt   <= alarm_cnt_nxt;
      fan_on      <= fan_nxt;
      buzzer      <= buzzer_nxt;
      valve_close <= valve_nxt;
    end
  end

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Self-checking bench for gas_alarm_controller: a run-length reference model
// pushes expected outputs per driven sample; they are popped after each edge.
module tb_gas_alarm_controller;

  localparam int unsigned WARN_LVL    = 3;
  localparam int unsigned ALARM_LVL   = 5;
  localparam int unsigned PERSIST     = 4;
  localparam int unsigned COOL_CYCLES = 16;

  logic       clk;
  logic       arst;
  logic [2:0] level;
  logic       ack;
  logic [1:0] state;
  logic       fan_on;
  logic       buzzer;
  logic       valve_close;
  logic [7:0] alarm_cnt;

  typedef struct {
    int st;
    int fan;
    int buz;
    int valve;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (run lengths are unbounded, not saturating)
  int m_state = 0;
  int m_up_run = 0;
  int m_dn_run = 0;
  int m_cool_t = 0;
  int m_mute = 0;
  int m_cnt = 0;

  gas_alarm_controller #(
    .WARN_LVL(WARN_LVL), .ALARM_LVL(ALARM_LVL),
    .PERSIST(PERSIST), .COOL_CYCLES(COOL_CYCLES)
  ) dut (
    .clk(clk), .arst(arst), .level(level), .ack(ack),
    .state(state), .fan_on(fan_on), .buzzer(buzzer),
    .valve_close(valve_close), .alarm_cnt(alarm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model(input int lvl, input int a, input int r);
    int thr;
    int ns;
    int latch;
    exp_t e;
`ifdef GAS_ALARM_LATCH_EN
    latch = 1;
`else
    latch = 0;
`endif
    if (r != 0) begin
      m_state = 0; m_up_run = 0; m_dn_run = 0; m_cool_t = 0; m_mute = 0; m_cnt = 0;
    end else begin
      thr = (m_state == 1) ? ALARM_LVL : WARN_LVL;
      m_up_run = (lvl >= thr) ? m_up_run + 1 : 0;
      m_dn_run = (lvl < WARN_LVL) ? m_dn_run + 1 : 0;
      ns = m_state;
      case (m_state)
        0: if (m_up_run >= PERSIST) ns = 1;
        1: if (m_up_run >= PERSIST) ns = 2; else if (m_dn_run >= PERSIST) ns = 3;
        2: if (m_dn_run >= PERSIST && (latch == 0 || a != 0)) ns = 3;
        default: if (m_up_run >= PERSIST) ns = 1; else if (m_cool_t == COOL_CYCLES - 1) ns = 0;
      endcase
      if (m_state == 2 && a != 0) m_mute = 1;
      if (ns != m_state) begin
        m_up_run = 0; m_dn_run = 0; m_cool_t = 0;
        if (ns == 2 && m_cnt < 255) m_cnt++;
        if (ns != 2) m_mute = 0;
      end else if (m_state == 3) begin
        m_cool_t++;
      end
      m_state = ns;
    end
    e.st    = m_state;
    e.fan   = (m_state != 0) ? 1 : 0;
    e.valve = (m_state == 2) ? 1 : 0;
    e.buz   = (m_state == 2 && m_mute == 0) ? 1 : 0;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  // Drive one sample, let one edge register it, compare against the scoreboard
  task automatic step(input int lvl, input int a, input int r);
    exp_t e;
    level = 3'(lvl);
    ack   = a[0];
    arst  = r[0];
    model(lvl, a, r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_state", 32'(state), 32'(e.st));
      check("sb_fan", 32'(fan_on), 32'(e.fan));
      check("sb_buzzer", 32'(buzzer), 32'(e.buz));
      check("sb_valve", 32'(valve_close), 32'(e.valve));
      check("sb_alarm_cnt", 32'(alarm_cnt), 32'(e.cnt));
    end
  endtask

  task automatic reach_cool();
    repeat (4) step(3, 0, 0);
    repeat (4) step(6, 0, 0);
    repeat (4) step(0, 1, 0);
  endtask

  initial begin
    level = 3'd7; ack = 1'b0; arst = 1'b1;

    // Reset with a high level present
    step(7, 0, 1);
    step(7, 0, 1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_fan", 32'(fan_on), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_valve", 32'(valve_close), 32'd0);
    check("rst_alarm_cnt", 32'(alarm_cnt), 32'd0);

    // Escalation IDLE -> WARN -> ALARM
    repeat (3) step(3, 0, 0);
    check("esc_pre_warn", 32'(state), 32'd0);
    step(3, 0, 0);
    check("esc_warn_state", 32'(state), 32'd1);
    check("esc_warn_fan", 32'(fan_on), 32'd1);
    repeat (4) step(6, 0, 0);
    check("esc_alarm_state", 32'(state), 32'd2);
    check("esc_alarm_valve", 32'(valve_close), 32'd1);
    check("esc_alarm_buzzer", 32'(buzzer), 32'd1);
    check("esc_alarm_cnt", 32'(alarm_cnt), 32'd1);

    // Acknowledge mutes, valve stays closed
    step(6, 1, 0);
    check("ack_buzzer", 32'(buzzer), 32'd0);
    check("ack_valve", 32'(valve_close), 32'd1);

    // Recovery through COOL
    repeat (4) step(0, 0, 0);
`ifdef GAS_ALARM_LATCH_EN
    check("latch_hold", 32'(state), 32'd2);
    step(0, 1, 0);
`endif
    check("rec_cool", 32'(state), 32'd3);
    repeat (15) step(0, 0, 0);
    check("cool_last", 32'(state), 32'd3);
    step(0, 0, 0);
    check("cool_done_state", 32'(state), 32'd0);
    check("cool_done_fan", 32'(fan_on), 32'd0);

    // Glitch rejection
    for (int i = 0; i < 7; i++) begin
      step((i == 3) ? 2 : 3, 0, 0);
      check("glitch_state", 32'(state), 32'd0);
    end
    step(0, 0, 0);

    // COOL re-trigger goes straight back to WARN
    reach_cool();
    check("retrig_cool", 32'(state), 32'd3);
    repeat (8) step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(4, 0, 0);
      check("retrig_hold", 32'(state), 32'd3);
    end
    step(4, 0, 0);
    check("retrig_warn", 32'(state), 32'd1);

    // Reset mid-ALARM
    repeat (4) step(6, 0, 0);
    check("mid_alarm", 32'(state), 32'd2);
    step(6, 1, 1);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_fan", 32'(fan_on), 32'd0);
    check("mid_rst_buzzer", 32'(buzzer), 32'd0);
    check("mid_rst_valve", 32'(valve_close), 32'd0);
    check("mid_rst_cnt", 32'(alarm_cnt), 32'd0);

    // Alarm counter saturation
    step(0, 0, 0);
    for (int i = 0; i < 257; i++) begin
      reach_cool();
      repeat (16) step(0, 0, 0);
      if (i == 254) check("sat_reach", 32'(alarm_cnt), 32'd255);
    end
    check("sat_hold", 32'(alarm_cnt), 32'd255);
    check("sat_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_alarm_controller.md
# gas_alarm_controller

Supervisory controller that sits downstream of the gas detector sensor and drives the ventilation fan, buzzer and gas shut-off valve. It consumes the sensor's 3-bit gas-level output, qualifies it with a persistence filter and sequences the outputs through a four-state escalation/recovery machine. It also keeps a saturating count of alarm events for the status display.

## Interface
- WARN_LVL, 3, level at or above which ventilation starts (1..7)
- ALARM_LVL, 5, level at or above which the alarm fires (WARN_LVL..7)
- PERSIST, 4, consecutive samples a condition must hold before a transition (1..255)
- COOL_CYCLES, 16, fan run-on cycles after the gas clears (1..65535)

- clk  in  1  system clock; all logic on the rising edge
- arst  in  1  reset, synchronous, active-high
- level  in  3  gas level from the detector sensor, sampled every clk
- ack  in  1  user acknowledge; level-sensitive, sampled every clk
- state  out  2  current FSM state: 0 IDLE, 1 WARN, 2 ALARM, 3 COOL
- fan_on  out  1  ventilation fan enable
- buzzer  out  1  audible alarm
- valve_close  out  1  gas supply shut-off
- alarm_cnt  out  8  number of ALARM entries, saturates at 255

## Operation
- Outputs are a Moore decode of the registered state, except buzzer, which also depends on the mute flag.
  - IDLE: all outputs 0.
  - WARN: fan_on=1.
  - ALARM: fan_on=1, valve_close=1, buzzer=~mute.
  - COOL: fan_on=1.
- up_cnt counts consecutive samples with level ≥ the state's up-threshold:
  - IDLE and COOL: WARN_LVL.
  - WARN: ALARM_LVL.
  - ALARM: up_cnt is unused.
- dn_cnt counts consecutive samples with level < WARN_LVL. It is used in WARN and ALARM.
- Counter update rules:
  - A failing sample clears the counter.
  - Both counters clear on every state transition.
  - Counters saturate at PERSIST.
- Transitions fire at the edge that registers the PERSIST-th consecutive qualifying sample:
  - IDLE → WARN on the up condition.
  - WARN → ALARM on the up condition. WARN → COOL on the dn condition. The two conditions are mutually exclusive because ALARM_LVL ≥ WARN_LVL.
  - ALARM → COOL on the dn condition (subject to Configuration).
  - COOL → WARN on the up condition. Otherwise, COOL → IDLE when cool_cnt reaches COOL_CYCLES-1.
  - Priority in COOL: up condition first, then timeout.
- cool_cnt (16 bit) clears on entry to COOL and increments every cycle in COOL.
- Mute flag:
  - ack=1 while in ALARM sets mute.
  - mute clears on ALARM exit and on reset.
  - ack outside ALARM has no effect.
- alarm_cnt increments on the edge where state becomes ALARM. It holds at 255.
- Reset (arst=1 at an edge, at any time including mid-ALARM or mid-COOL):
  - state=IDLE; up_cnt, dn_cnt, cool_cnt, mute and alarm_cnt all cleared.
  - Therefore every output reads 0 after reset.
  - Reset dominates all other inputs in the same cycle.

## Timing
- Qualification latency: a level held from edge k onward changes state at edge k+PERSIST-1. The outputs follow in the same cycle, since they are decoded from the state.
- Full escalation from IDLE to ALARM takes at least 2·PERSIST samples.
- COOL dwell is exactly COOL_CYCLES cycles when no re-trigger occurs.
- buzzer drops in the cycle after ack is sampled high.
- level is assumed already synchronous to clk; no input synchronizer is included.

## Configuration
- GAS_ALARM_LATCH_EN:
  - Defined: ALARM is latching. ALARM → COOL requires the dn condition to be satisfied (dn_cnt = PERSIST) and ack=1 in the same or a later cycle. The dn condition stays satisfied until a sample at or above WARN_LVL clears it. ack still mutes the buzzer.
  - Undefined: ALARM exits on the dn condition alone. ack only mutes the buzzer.

## Test plan
- Reset: arst=1 for 2 cycles with level=7 → state=0, fan_on=buzzer=valve_close=0, alarm_cnt=0.
- Escalation:
  - level=3 for 4 cycles → state=1, fan_on=1.
  - Then level=6 for 4 cycles → state=2, valve_close=1, buzzer=1, alarm_cnt=1.
- Glitch rejection: from IDLE, level=3,3,3,2,3,3,3 → state stays 0 throughout.
- Recovery:
  - In ALARM, assert ack once → buzzer=0, valve_close=1.
  - Then level=0 for 4 cycles → state=3 (without macro).
  - After 16 further cycles → state=0, fan_on=0.
  - With GAS_ALARM_LATCH_EN: state stays 2 until ack=1 after the 4 low samples, then goes to 3.
- COOL re-trigger: in COOL at cycle 8, level=4 for 4 cycles → state=1 with no pass through IDLE. Reset mid-ALARM → all outputs 0 on the next edge.
- Saturation: drive 256 IDLE→ALARM→COOL→IDLE cycles → alarm_cnt=255 and holds.
